l1_cache_ctrl: RTL and testbench

- 1 MB, 4-way set-associative, write-back, write-allocate L1 data cache.
- Sits between a 32-bit word requester and a main memory with a 256-bit line-wide port.
- Serves one request at a time; on a miss it writes back a dirty victim line and fills from memory.
- Provides a ram_test mode for direct data-array access.

---
 rtl/l1_cache_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_l1_cache_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/l1_cache_ctrl.sv
// 4-way set-associative write-back/write-allocate L1 data cache controller.
// One request in flight; misses evict (writing back if dirty) and refill a full line.
module l1_cache_ctrl #(
    parameter int TAG_W  = 14,
    parameter int IDX_W  = 13,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       a,
    input  logic [3:0]        be,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       wd,
    input  logic              ram_test,
    output logic [31:0]       rd,
    output logic              valid,
    output logic [31:0]       mm_a,
    output logic [LINE_W-1:0] mm_wd,
    output logic              mm_write,
    output logic              mm_read,
    input  logic [LINE_W-1:0] mm_rd,
    input  logic              mm_valid
);

    localparam int SETS = 1 << IDX_W;

    typedef enum logic [2:0] {IDLE, WB, FILL_REQ, FILL_WAIT, RESP} state_t;
    state_t state, next_state;

    // Per-set metadata is packed {valid[3:0], mod[3:0], lru[2:0]}.
    logic [4*TAG_W-1:0] tag_mem  [SETS];
    logic [10:0]        set_meta [SETS];
    logic [LINE_W-1:0]  data_mem [4][SETS];

    logic [TAG_W-1:0]   req_tag;
    logic [IDX_W-1:0]   req_idx;
    logic [2:0]         req_word;
    logic [3:0]         req_be;
    logic [31:0]        req_wd;
    logic               req_read;
    logic [1:0]         req_way;

    logic [TAG_W-1:0]   cur_tag;
    logic [IDX_W-1:0]   cur_idx;
    logic [10:0]        cur_meta;
    logic [4*TAG_W-1:0] cur_tags;
    logic [3:0]         cur_vld, cur_mod;
    logic [2:0]         cur_lru;
    logic               hit, victim_dirty, miss_go, fill_go;
    logic [1:0]         hit_way, victim;

    logic               acc_en, acc_rd, acc_meta;
    logic [1:0]         acc_way;
    logic [2:0]         acc_word;
    logic [3:0]         acc_be;
    logic [31:0]        acc_wd;
    logic               meta_we;
    logic [10:0]        meta_new;
    logic               unused_addr_bits;

    assign unused_addr_bits = ^a[1:0];

    function automatic logic [2:0] plru_touch(input logic [2:0] lru, input logic [1:0] w);
        logic [2:0] n;
        n = lru;
        case (w)
            2'd0: begin n[0] = 1'b1; n[1] = 1'b1; end
            2'd1: begin n[0] = 1'b1; n[1] = 1'b0; end
            2'd2: begin n[0] = 1'b0; n[2] = 1'b1; end
            default: begin n[0] = 1'b0; n[2] = 1'b0; end
        endcase
        return n;
    endfunction

    // Lookups use the live address while idle, the latched request afterwards.
    assign cur_tag  = (state == IDLE) ? a[31 -: TAG_W] : req_tag;
    assign cur_idx  = (state == IDLE) ? a[5 +: IDX_W] : req_idx;
    assign cur_meta = set_meta[cur_idx];
    assign cur_tags = tag_mem[cur_idx];
    assign cur_vld  = cur_meta[10:7];
    assign cur_mod  = cur_meta[6:3];
    assign cur_lru  = cur_meta[2:0];

    always_comb begin
        hit     = 1'b0;
        hit_way = 2'd0;
        for (int w = 0; w < 4; w++) begin
            if (cur_vld[w] && cur_tags[w*TAG_W +: TAG_W] == cur_tag) begin
                hit     = 1'b1;
                hit_way = 2'(w);
            end
        end
    end

    always_comb begin
        if (!cur_vld[0])      victim = 2'd0;
        else if (!cur_vld[1]) victim = 2'd1;
        else if (!cur_vld[2]) victim = 2'd2;
        else if (!cur_vld[3]) victim = 2'd3;
        else                  victim = cur_lru[0] ? (cur_lru[2] ? 2'd3 : 2'd2)
                                                  : (cur_lru[1] ? 2'd1 : 2'd0);
    end

    assign victim_dirty = cur_vld[victim] & cur_mod[victim];
    assign miss_go      = (state == IDLE) && (read || write) && !ram_test && !hit;
    assign fill_go      = (state == FILL_WAIT) && mm_valid;

    // A single word access port shared by idle hits, ram_test and the post-fill response.
    always_comb begin
        acc_en   = 1'b0;
        acc_rd   = 1'b0;
        acc_meta = 1'b0;
        acc_way  = hit_way;
        acc_word = a[4:2];
        acc_be   = be;
        acc_wd   = wd;
        if (state == IDLE && (read || write)) begin
            if (ram_test) begin
                acc_en  = 1'b1;
                acc_rd  = read;
                acc_way = a[19:18];
            end else if (hit) begin
                acc_en   = 1'b1;
                acc_rd   = read;
                acc_meta = 1'b1;
            end
        end else if (state == RESP) begin
            acc_en   = 1'b1;
            acc_rd   = req_read;
            acc_meta = 1'b1;
            acc_way  = req_way;
            acc_word = req_word;
            acc_be   = req_be;
            acc_wd   = req_wd;
        end
    end

    always_comb begin
        meta_we  = 1'b0;
        meta_new = cur_meta;
        if (acc_en && acc_meta) begin
            meta_we       = 1'b1;
            meta_new[2:0] = plru_touch(cur_lru, acc_way);
            if (!acc_rd) meta_new[3 + acc_way] = 1'b1;
        end else if (fill_go) begin
            meta_we              = 1'b1;
            meta_new[7 + req_way] = 1'b1;
            meta_new[3 + req_way] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (miss_go) next_state = victim_dirty ? WB : FILL_REQ;
            WB:        next_state = FILL_REQ;
            FILL_REQ:  next_state = FILL_WAIT;
            FILL_WAIT: if (mm_valid) next_state = RESP;
            RESP:      next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    always_comb begin
        mm_write = (state == WB);
        mm_read  = (state == FILL_REQ);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd       <= '0;
            valid    <= 1'b0;
            mm_a     <= '0;
            mm_wd    <= '0;
            req_tag  <= '0;
            req_idx  <= '0;
            req_word <= '0;
            req_be   <= '0;
            req_wd   <= '0;
            req_read <= 1'b0;
            req_way  <= '0;
            for (int s = 0; s < SETS; s++) set_meta[s] <= '0;
        end else begin
            valid <= acc_en && acc_rd;
            if (acc_en && acc_rd) rd <= data_mem[acc_way][cur_idx][{acc_word, 5'b0} +: 32];
            if (meta_we) set_meta[cur_idx] <= meta_new;
            if (miss_go) begin
                req_tag  <= a[31 -: TAG_W];
                req_idx  <= a[5 +: IDX_W];
                req_word <= a[4:2];
                req_be   <= be;
                req_wd   <= wd;
                req_read <= read;
                req_way  <= victim;
                if (victim_dirty) begin
                    mm_a  <= {cur_tags[victim*TAG_W +: TAG_W], cur_idx, 5'b0};
                    mm_wd <= data_mem[victim][cur_idx];
                end
            end
            if (next_state == FILL_REQ) mm_a <= {cur_tag, cur_idx, 5'b0};
        end
    end

    // Tags and data are never cleared; writes are simply suppressed while in reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (fill_go) begin
                data_mem[req_way][req_idx]                 <= mm_rd;
                tag_mem[req_idx][req_way*TAG_W +: TAG_W]   <= req_tag;
            end
            if (acc_en && !acc_rd) begin
                for (int b = 0; b < 4; b++) begin
                    if (acc_be[b])
                        data_mem[acc_way][cur_idx][{acc_word, b[1:0], 3'b000} +: 8] <= acc_wd[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_l1_cache_ctrl.sv
// Scoreboard bench for l1_cache_ctrl: a backing-memory responder plus an architectural word model.
module tb_l1_cache_ctrl;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [31:0]  a = '0;
    logic [3:0]   be = '0;
    logic         read = 1'b0;
    logic         write = 1'b0;
    logic [31:0]  wd = '0;
    logic         ram_test = 1'b0;
    logic [31:0]  rd;
    logic         valid;
    logic [31:0]  mm_a;
    logic [255:0] mm_wd;
    logic         mm_write;
    logic         mm_read;
    logic [255:0] mm_rd = '0;
    logic         mm_valid = 1'b0;

    l1_cache_ctrl dut (
        .clk(clk), .reset(reset), .a(a), .be(be), .read(read), .write(write), .wd(wd),
        .ram_test(ram_test), .rd(rd), .valid(valid), .mm_a(mm_a), .mm_wd(mm_wd),
        .mm_write(mm_write), .mm_read(mm_read), .mm_rd(mm_rd), .mm_valid(mm_valid)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int valid_count = 0, rd_count = 0, wr_count = 0;
    int last_valid_cyc = 0, mv_cyc = 0, rd_cyc = 0, wr_cyc = 0;
    int pend_cnt = 0;
    logic [31:0]  pend_a = '0, last_rd_a = '0, last_wr_a = '0;
    logic [255:0] last_wr_d = '0;
    logic [31:0]  exp_q [$];
    logic [31:0]  arch [logic [31:0]];
    logic [255:0] backing [logic [31:0]];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string tag, input logic [255:0] got, input logic [255:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pat(input logic [31:0] addr);
        if (addr == 32'h48) return 32'hDEADBEEF;
        return (addr * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] addr);
        logic [31:0] w;
        w = addr & ~32'h3;
        if (arch.exists(w)) return arch[w];
        return pat(w);
    endfunction

    function automatic logic [255:0] mem_line(input logic [31:0] la);
        logic [255:0] l;
        if (backing.exists(la)) return backing[la];
        for (int i = 0; i < 8; i++) l[32*i +: 32] = pat(la + 32'(4*i));
        return l;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Rd scoreboard: every valid pulse pops one expected word.
    always @(negedge clk) begin
        if (valid) begin
            valid_count++;
            last_valid_cyc = cyc;
            if (exp_q.size() == 0) check_output("queue_empty_at_valid", 256'(exp_q.size()), 256'd1);
            else check_output("rd", rd, exp_q.pop_front());
        end
    end

    // Main memory: fills arrive three cycles after mm_read; write-backs update the backing store.
    initial forever begin
        @(negedge clk);
        mm_valid = 1'b0;
        if (reset) pend_cnt = 0;
        else begin
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    mm_valid = 1'b1;
                    mm_rd    = mem_line(pend_a);
                    mv_cyc   = cyc;
                end
            end
            if (mm_write) begin
                wr_count++; wr_cyc = cyc; last_wr_a = mm_a; last_wr_d = mm_wd;
                backing[mm_a] = mm_wd;
            end
            if (mm_read) begin
                rd_count++; rd_cyc = cyc; last_rd_a = mm_a; pend_a = mm_a; pend_cnt = 3;
            end
        end
    end

    task automatic apply_stimulus(input bit is_read, input bit also_write, input logic [31:0] addr,
                                  input logic [3:0] be_v, input logic [31:0] wd_v, input bit ram,
                                  input logic [31:0] exp_rd, output int lat);
        int start, vc;
        logic [31:0] w, cur;
        if (is_read) exp_q.push_back(exp_rd);
        else if (!ram) begin
            w = addr & ~32'h3;
            cur = ref_word(w);
            for (int b = 0; b < 4; b++) if (be_v[b]) cur[8*b +: 8] = wd_v[8*b +: 8];
            arch[w] = cur;
        end
        tick();
        read = is_read; write = !is_read || also_write; a = addr; be = be_v; wd = wd_v; ram_test = ram;
        start = cyc; vc = valid_count;
        tick();
        read = 1'b0; write = 1'b0; ram_test = 1'b0; a = $urandom; wd = $urandom; be = 4'($urandom);
        lat = 0;
        if (is_read) begin
            for (int i = 0; i < 40 && valid_count == vc; i++) tick();
            if (valid_count == vc) check_output("read_timeout", 256'(valid_count), 256'(vc + 1));
            lat = last_valid_cyc - start;
            repeat (2) tick();
        end else repeat (12) tick();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int lat, rc0, wc0, vc0;
        logic [255:0] exp_line;

        repeat (3) tick();
        check_output("reset_rd", rd, 0);
        check_output("reset_valid", valid, 0);
        check_output("reset_strobes", {mm_read, mm_write}, 0);
        check_output("reset_mm_a", mm_a, 0);
        check_output("reset_mm_wd", mm_wd, 0);
        check_output("reset_meta2", dut.set_meta[2], 0);
        reset = 1'b0;
        tick();

        rc0 = rd_count;
        apply_stimulus(1, 0, 32'h48, 4'h0, 0, 0, 32'hDEADBEEF, lat);
        check_output("miss_fill_count", 256'(rd_count), 256'(rc0 + 1));
        check_output("miss_mm_a", last_rd_a, 32'h40);
        check_output("miss_latency", 256'(last_valid_cyc - mv_cyc), 256'd2);
        check_output("meta2_after_fill", dut.set_meta[2], 11'b0001_0000_011);

        rc0 = rd_count;
        apply_stimulus(1, 0, 32'h48, 4'h0, 0, 0, 32'hDEADBEEF, lat);
        check_output("hit_latency", 256'(lat), 256'd1);
        check_output("hit_no_fill", 256'(rd_count), 256'(rc0));

        apply_stimulus(0, 0, 32'h48, 4'b0011, 32'h11223344, 0, 0, lat);
        apply_stimulus(1, 0, 32'h48, 4'h0, 0, 0, 32'hDEAD3344, lat);
        check_output("meta2_after_write", dut.set_meta[2], 11'b0001_0001_011);

        apply_stimulus(1, 0, 32'h40048, 4'h0, 0, 0, ref_word(32'h40048), lat);
        apply_stimulus(1, 0, 32'h80048, 4'h0, 0, 0, ref_word(32'h80048), lat);
        apply_stimulus(1, 0, 32'hC0048, 4'h0, 0, 0, ref_word(32'hC0048), lat);
        check_output("meta2_full_set", dut.set_meta[2], 11'b1111_0001_000);

        wc0 = wr_count;
        for (int i = 0; i < 8; i++) exp_line[32*i +: 32] = ref_word(32'h40 + 32'(4*i));
        apply_stimulus(1, 0, 32'h100048, 4'h0, 0, 0, ref_word(32'h100048), lat);
        check_output("dirty_wb_count", 256'(wr_count), 256'(wc0 + 1));
        check_output("dirty_wb_addr", last_wr_a, 32'h40);
        check_output("dirty_wb_data", last_wr_d, exp_line);
        check_output("dirty_wb_to_read_gap", 256'(rd_cyc - wr_cyc), 256'd1);
        check_output("dirty_fill_addr", last_rd_a, 32'h100040);

        rc0 = rd_count;
        apply_stimulus(1, 0, 32'h100048, 4'h0, 0, 0, ref_word(32'h100048), lat);
        apply_stimulus(1, 0, 32'h40048, 4'h0, 0, 0, ref_word(32'h40048), lat);
        apply_stimulus(1, 0, 32'h80048, 4'h0, 0, 0, ref_word(32'h80048), lat);
        apply_stimulus(1, 0, 32'hC0048, 4'h0, 0, 0, ref_word(32'hC0048), lat);
        apply_stimulus(1, 0, 32'h100048, 4'h0, 0, 0, ref_word(32'h100048), lat);
        check_output("seq_all_hits", 256'(rd_count), 256'(rc0));
        check_output("seq_lru", dut.set_meta[2][2:0], 3'b011);

        wc0 = wr_count;
        apply_stimulus(1, 0, 32'h140048, 4'h0, 0, 0, ref_word(32'h140048), lat);
        check_output("clean_evict_no_wb", 256'(wr_count), 256'(wc0));
        rc0 = rd_count;
        apply_stimulus(1, 0, 32'hC0048, 4'h0, 0, 0, ref_word(32'hC0048), lat);
        apply_stimulus(1, 0, 32'h40048, 4'h0, 0, 0, ref_word(32'h40048), lat);
        check_output("survivors_hit", 256'(rd_count), 256'(rc0));
        apply_stimulus(1, 0, 32'h80048, 4'h0, 0, 0, ref_word(32'h80048), lat);
        check_output("way2_was_evicted", 256'(rd_count), 256'(rc0 + 1));

        rc0 = rd_count; wc0 = wr_count;
        apply_stimulus(0, 0, 32'h400AC, 4'hF, 32'hCAFEF00D, 1, 0, lat);
        apply_stimulus(1, 0, 32'h400AC, 4'h0, 0, 1, 32'hCAFEF00D, lat);
        check_output("ram_test_latency", 256'(lat), 256'd1);
        check_output("ram_test_no_traffic", {256'(rd_count), 256'(wr_count)}, {256'(rc0), 256'(wc0)});
        check_output("ram_test_meta5", dut.set_meta[5], 0);

        apply_stimulus(1, 1, 32'h48, 4'hF, 32'h0, 0, ref_word(32'h48), lat);
        apply_stimulus(1, 0, 32'h48, 4'h0, 0, 0, ref_word(32'h48), lat);

        vc0 = valid_count; rc0 = rd_count;
        tick();
        read = 1'b1; a = 32'h200048;
        tick();
        read = 1'b0;
        tick();
        check_output("abort_fill_requested", 256'(rd_count), 256'(rc0 + 1));
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        repeat (10) tick();
        check_output("abort_no_valid", 256'(valid_count), 256'(vc0));
        check_output("abort_meta2", dut.set_meta[2], 0);
        check_output("abort_rd", rd, 0);
        check_output("abort_mm_a", mm_a, 0);
        apply_stimulus(1, 0, 32'h48, 4'h0, 0, 0, 32'hDEAD3344, lat);

        check_output("queue_drained", 256'(exp_q.size()), 256'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
